// File: rtl/ll_pkg.sv
// Shared types for the linked-list write path: opcodes, response status, controller states
// and the end-of-list pointer helper.
package ll_pkg;

    typedef enum logic [2:0] {
        OpInsAlloc = 3'd0,
        OpWrNode   = 3'd1,
        OpWrData   = 3'd2,
        OpWrLink   = 3'd3,
        OpInsAfter = 3'd4
    } t_ll_wr_op;

    typedef enum logic [1:0] {
        StatOk      = 2'd0,
        StatErrFull = 2'd1,
        StatErrPtr  = 2'd2,
        StatErrOp   = 2'd3
    } t_ll_wr_status;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRelink,
        StPop,
        StResp
    } t_ll_wr_v3_state;

    // All-ones value of a ptr_w-bit pointer, returned in the low bits of a 32-bit word.
    function automatic logic [31:0] ll_null_ptr(input int unsigned ptr_w);
        return (ptr_w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << ptr_w) - 32'h1);
    endfunction

endpackage

// File: rtl/ll_mem_wr_port.sv
// One memory write channel: holds vld/addr/data from start until done is seen, and keeps
// a sticky done flag so the controller can wait for several channels in any order.
module ll_mem_wr_port #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              clear,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_data,
    input  logic              wr_done,
    output logic              wr_vld,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              done_seen
);

    logic done_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_vld  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done_q  <= 1'b0;
        end else if (start) begin
            wr_vld  <= 1'b1;
            wr_addr <= start_addr;
            wr_data <= start_data;
            done_q  <= 1'b0;
        end else if (clear) begin
            wr_vld  <= 1'b0;
            done_q  <= 1'b0;
        end else if (wr_vld && wr_done) begin
            wr_vld  <= 1'b0;
            done_q  <= 1'b1;
        end
    end

    // Includes the done arriving this cycle so the controller can leave on the same edge.
    assign done_seen = done_q | (wr_vld & wr_done);

endmodule

// File: rtl/ll_wr_ctrl_v3.sv
// Linked-list write controller: takes one command, sequences data/nxtptr writes, relinks
// for mid-list inserts, pops the free pointer after all writes, then returns a response.
module ll_wr_ctrl_v3
    import ll_pkg::*;
#(
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      PTR_W    = 5,
    parameter logic [PTR_W-1:0] NULL_PTR = PTR_W'(ll_null_ptr(PTR_W))
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [2:0]        cmd_op,
    input  logic [PTR_W-1:0]  cmd_node_ptr,
    input  logic [PTR_W-1:0]  cmd_link_ptr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [PTR_W-1:0]  rsp_ptr,
    output logic [1:0]        rsp_status,
    output logic              data_mem_wr_vld,
    output logic [PTR_W-1:0]  data_mem_wr_addr,
    output logic [DATA_W-1:0] data_mem_wr_data,
    input  logic              data_mem_wr_done,
    output logic              nxtptr_mem_wr_vld,
    output logic [PTR_W-1:0]  nxtptr_mem_wr_addr,
    output logic [PTR_W-1:0]  nxtptr_mem_wr_data,
    input  logic              nxtptr_mem_wr_done,
    input  logic [PTR_W-1:0]  free_ptr,
    input  logic              free_empty,
    output logic              free_pop
);

    t_ll_wr_v3_state  state_q;
    t_ll_wr_op        op_q;
    t_ll_wr_status    status_q;
    logic [PTR_W-1:0] node_q, alloc_q, rsp_ptr_q;

    logic             hs, go, op_legal, op_alloc;
    t_ll_wr_status    hs_status;
    logic [PTR_W-1:0] tgt_ptr;

    always_comb begin
        op_legal  = cmd_op <= 3'd4;
        op_alloc  = (cmd_op == OpInsAlloc) || (cmd_op == OpInsAfter);
        hs_status = StatOk;
        if (!op_legal) begin
            hs_status = StatErrOp;
        end else if ((cmd_op != OpInsAlloc) && (cmd_node_ptr == NULL_PTR)) begin
            hs_status = StatErrPtr;
        end else if (op_alloc && free_empty) begin
            hs_status = StatErrFull;
        end
        tgt_ptr = op_alloc ? free_ptr : cmd_node_ptr;
    end

    assign cmd_rdy = reset_n & (state_q == StIdle);
    assign hs      = cmd_vld & cmd_rdy;
    assign go      = hs & (hs_status == StatOk);

    logic              d_start, d_vld, d_done;
    logic [PTR_W-1:0]  d_addr;
    logic [DATA_W-1:0] d_data;
    logic              n_start, n_vld, n_done;
    logic [PTR_W-1:0]  n_addr, n_data, n_start_addr, n_start_data;
    logic              need_data, need_nxt, write_done, relink_start, port_clear;

    assign need_data    = op_q != OpWrLink;
    assign need_nxt     = op_q != OpWrData;
    assign write_done   = (!need_data || d_done) && (!need_nxt || n_done);
    // The nxtptr channel is reused for the relink write once the first pass completes.
    assign relink_start = (state_q == StWrite) && write_done && (op_q == OpInsAfter);
    assign d_start      = go && (cmd_op != OpWrLink);
    assign n_start      = (go && (cmd_op != OpWrData)) || relink_start;
    assign n_start_addr = relink_start ? node_q : tgt_ptr;
    assign n_start_data = relink_start ? alloc_q : cmd_link_ptr;
    assign port_clear   = state_q == StResp;

    ll_mem_wr_port #(.ADDR_W(PTR_W), .DATA_W(DATA_W)) u_data_port (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (d_start),
        .clear      (port_clear),
        .start_addr (tgt_ptr),
        .start_data (cmd_data),
        .wr_done    (data_mem_wr_done),
        .wr_vld     (d_vld),
        .wr_addr    (d_addr),
        .wr_data    (d_data),
        .done_seen  (d_done)
    );

    ll_mem_wr_port #(.ADDR_W(PTR_W), .DATA_W(PTR_W)) u_nxtptr_port (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (n_start),
        .clear      (port_clear),
        .start_addr (n_start_addr),
        .start_data (n_start_data),
        .wr_done    (nxtptr_mem_wr_done),
        .wr_vld     (n_vld),
        .wr_addr    (n_addr),
        .wr_data    (n_data),
        .done_seen  (n_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            op_q      <= OpInsAlloc;
            status_q  <= StatOk;
            node_q    <= '0;
            alloc_q   <= '0;
            rsp_ptr_q <= '0;
        end else begin
            case (state_q)
                StIdle: if (hs) begin
                    op_q      <= t_ll_wr_op'(cmd_op);
                    node_q    <= cmd_node_ptr;
                    alloc_q   <= free_ptr;
                    rsp_ptr_q <= (op_alloc && (hs_status == StatOk)) ? free_ptr : cmd_node_ptr;
                    status_q  <= hs_status;
                    state_q   <= go ? StWrite : StResp;
                end
                StWrite: if (write_done) begin
                    state_q <= (op_q == OpInsAfter) ? StRelink :
                               (op_q == OpInsAlloc) ? StPop : StResp;
                end
                StRelink: if (n_done) state_q <= StPop;
                StPop:    state_q <= StResp;
                StResp:   if (rsp_rdy) state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Reset is synchronous, so outputs are also gated to read zero while it is held.
    assign rsp_vld            = reset_n & (state_q == StResp);
    assign rsp_ptr            = reset_n ? rsp_ptr_q : '0;
    assign rsp_status         = reset_n ? status_q : StatOk;
    assign free_pop           = reset_n & (state_q == StPop);
    assign data_mem_wr_vld    = reset_n & d_vld;
    assign data_mem_wr_addr   = reset_n ? d_addr : '0;
    assign data_mem_wr_data   = reset_n ? d_data : '0;
    assign nxtptr_mem_wr_vld  = reset_n & n_vld;
    assign nxtptr_mem_wr_addr = reset_n ? n_addr : '0;
    assign nxtptr_mem_wr_data = reset_n ? n_data : '0;

endmodule

// File: tb/tb_ll_wr_ctrl_v3.sv
// Bench for ll_wr_ctrl_v3: directed scenarios plus random commands against a memory-image
// and latency model derived from the command rules.
module tb_ll_wr_ctrl_v3;

    localparam logic [4:0] NULLP = 5'h1F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_vld, cmd_rdy;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_node_ptr, cmd_link_ptr;
    logic [31:0] cmd_data;
    logic        rsp_vld, rsp_rdy;
    logic [4:0]  rsp_ptr;
    logic [1:0]  rsp_status;
    logic        data_mem_wr_vld, data_mem_wr_done;
    logic [4:0]  data_mem_wr_addr;
    logic [31:0] data_mem_wr_data;
    logic        nxtptr_mem_wr_vld, nxtptr_mem_wr_done;
    logic [4:0]  nxtptr_mem_wr_addr, nxtptr_mem_wr_data;
    logic [4:0]  free_ptr;
    logic        free_empty, free_pop;

    always #5 clk = ~clk;

    ll_wr_ctrl_v3 #(.DATA_W(32), .PTR_W(5)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cmd_vld            (cmd_vld),
        .cmd_rdy            (cmd_rdy),
        .cmd_op             (cmd_op),
        .cmd_node_ptr       (cmd_node_ptr),
        .cmd_link_ptr       (cmd_link_ptr),
        .cmd_data           (cmd_data),
        .rsp_vld            (rsp_vld),
        .rsp_rdy            (rsp_rdy),
        .rsp_ptr            (rsp_ptr),
        .rsp_status         (rsp_status),
        .data_mem_wr_vld    (data_mem_wr_vld),
        .data_mem_wr_addr   (data_mem_wr_addr),
        .data_mem_wr_data   (data_mem_wr_data),
        .data_mem_wr_done   (data_mem_wr_done),
        .nxtptr_mem_wr_vld  (nxtptr_mem_wr_vld),
        .nxtptr_mem_wr_addr (nxtptr_mem_wr_addr),
        .nxtptr_mem_wr_data (nxtptr_mem_wr_data),
        .nxtptr_mem_wr_done (nxtptr_mem_wr_done),
        .free_ptr           (free_ptr),
        .free_empty         (free_empty),
        .free_pop           (free_pop)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory images written by the DUT (obs) and predicted by the model (exp).
    logic [31:0] obs_data[32], exp_data[32];
    logic [4:0]  obs_nxt[32], exp_nxt[32];
    logic [4:0]  n_log_addr[4], n_log_data[4];
    int d_cnt, n_cnt, pop_cnt, exp_d_cnt, exp_n_cnt;
    int d_lat, n_lat;
    bit pop_early;

    initial begin : data_mem_model
        int waited;
        waited = 0;
        data_mem_wr_done = 1'b0;
        forever begin
            @(negedge clk);
            data_mem_wr_done = 1'b0;
            if (reset_n && data_mem_wr_vld) begin
                if (waited >= d_lat) begin
                    data_mem_wr_done = 1'b1;
                    obs_data[data_mem_wr_addr] = data_mem_wr_data;
                    d_cnt++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    initial begin : nxtptr_mem_model
        int waited;
        waited = 0;
        nxtptr_mem_wr_done = 1'b0;
        forever begin
            @(negedge clk);
            nxtptr_mem_wr_done = 1'b0;
            if (reset_n && nxtptr_mem_wr_vld) begin
                if (waited >= n_lat) begin
                    nxtptr_mem_wr_done = 1'b1;
                    obs_nxt[nxtptr_mem_wr_addr] = nxtptr_mem_wr_data;
                    if (n_cnt < 4) begin
                        n_log_addr[n_cnt] = nxtptr_mem_wr_addr;
                        n_log_data[n_cnt] = nxtptr_mem_wr_data;
                    end
                    n_cnt++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    initial begin : pop_monitor
        forever begin
            @(negedge clk);
            if (free_pop) begin
                pop_cnt++;
                if (d_cnt < exp_d_cnt || n_cnt < exp_n_cnt) pop_early = 1'b1;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_eq(tag, 64'({cmd_rdy, rsp_vld, rsp_ptr, rsp_status, data_mem_wr_vld,
                           data_mem_wr_addr, nxtptr_mem_wr_vld, nxtptr_mem_wr_addr,
                           nxtptr_mem_wr_data, free_pop}), 64'd0);
        check_eq({tag, "_data"}, 64'(data_mem_wr_data), 64'd0);
    endtask

    // Issue one command, model its effect, and check the whole transaction.
    task automatic run_cmd(input logic [2:0] op, input logic [4:0] node, input logic [4:0] link,
                           input logic [31:0] data, input logic [4:0] fp, input bit empty,
                           input int dl, input int nl, input int hold);
        int exp_status, exp_lat, exp_pops, wlat, lat;
        bit legal, alloc, ok, wd, wn;
        logic [4:0] newp;
        legal = op <= 3'd4;
        alloc = legal && (op == 3'd0 || op == 3'd4);
        if (!legal)                       exp_status = 3;
        else if (op != 3'd0 && node == NULLP) exp_status = 2;
        else if (alloc && empty)          exp_status = 1;
        else                              exp_status = 0;
        ok        = exp_status == 0;
        newp      = alloc ? fp : node;
        wd        = ok && op != 3'd3;
        wn        = ok && op != 3'd2;
        exp_pops  = (ok && alloc) ? 1 : 0;
        if (!ok) begin
            exp_lat = 1;
        end else begin
            wlat = 0;
            if (wd) wlat = dl;
            if (wn && nl > wlat) wlat = nl;
            exp_lat = (wlat + 1) + ((op == 3'd4) ? nl + 1 : 0) + (alloc ? 1 : 0) + 1;
        end
        if (wd) exp_data[newp] = data;
        if (wn) exp_nxt[newp] = link;
        if (ok && op == 3'd4) exp_nxt[node] = newp;

        @(negedge clk);
        d_lat = dl; n_lat = nl;
        d_cnt = 0; n_cnt = 0; pop_cnt = 0; pop_early = 1'b0;
        exp_d_cnt = wd ? 1 : 0;
        exp_n_cnt = (wn ? 1 : 0) + ((ok && op == 3'd4) ? 1 : 0);
        cmd_op = op; cmd_node_ptr = node; cmd_link_ptr = link; cmd_data = data;
        free_ptr = fp; free_empty = empty; cmd_vld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_rdy) break;
            @(negedge clk);
        end
        check_eq("cmd_accept", 64'(cmd_rdy), 64'd1);
        @(posedge clk);
        #1;
        // Scramble everything so late sampling of command fields or free_ptr shows up.
        cmd_vld = 1'b0;
        cmd_op = 3'($urandom); cmd_node_ptr = 5'($urandom); cmd_link_ptr = 5'($urandom);
        cmd_data = $urandom; free_ptr = 5'($urandom); free_empty = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_vld && lat < 64);
        check_eq("rsp_seen", 64'(rsp_vld), 64'd1);
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("status", 64'(rsp_status), 64'(exp_status));
        check_eq("resp_busy", 64'(cmd_rdy), 64'd0);
        if (ok) check_eq("rsp_ptr", 64'(rsp_ptr), 64'(newp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_vld", 64'(rsp_vld), 64'd1);
            check_eq("hold_rdy", 64'(cmd_rdy), 64'd0);
            check_eq("hold_stat", 64'(rsp_status), 64'(exp_status));
            if (ok) check_eq("hold_ptr", 64'(rsp_ptr), 64'(newp));
        end
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        rsp_rdy = 1'b0;
        @(negedge clk);
        check_eq("b2b_rdy", 64'(cmd_rdy), 64'd1);
        check_eq("rsp_drop", 64'(rsp_vld), 64'd0);
        check_eq("data_writes", 64'(d_cnt), 64'(exp_d_cnt));
        check_eq("nxt_writes", 64'(n_cnt), 64'(exp_n_cnt));
        check_eq("pops", 64'(pop_cnt), 64'(exp_pops));
        check_eq("pop_order", 64'(pop_early), 64'd0);
        if (wd) check_eq("data_word", 64'(obs_data[newp]), 64'(data));
        if (wn) begin
            check_eq("nxt0_addr", 64'(n_log_addr[0]), 64'(newp));
            check_eq("nxt0_data", 64'(n_log_data[0]), 64'(link));
        end
        if (ok && op == 3'd4) begin
            check_eq("relink_addr", 64'(n_log_addr[1]), 64'(node));
            check_eq("relink_data", 64'(n_log_data[1]), 64'(newp));
        end
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [4:0]  r_node, r_fp;
        reset_n = 1'b0; cmd_vld = 1'b0; cmd_op = '0; cmd_node_ptr = '0; cmd_link_ptr = '0;
        cmd_data = '0; rsp_rdy = 1'b0; free_ptr = '0; free_empty = 1'b0;
        d_lat = 0; n_lat = 0; d_cnt = 0; n_cnt = 0; pop_cnt = 0;
        exp_d_cnt = 0; exp_n_cnt = 0; pop_early = 1'b0;
        for (int i = 0; i < 32; i++) begin
            obs_data[i] = '0; exp_data[i] = '0; obs_nxt[i] = '0; exp_nxt[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            n_log_addr[i] = '0; n_log_data[i] = '0;
        end
        cmd_vld = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_outs");
        cmd_vld = 1'b0;
        reset_n = 1'b1;
        #1;
        check_eq("idle_rdy", 64'(cmd_rdy), 64'd1);
        check_eq("idle_rsp", 64'(rsp_vld), 64'd0);

        run_cmd(3'd0, 5'd0, 5'd7, 32'hDEADBEEF, 5'd3, 1'b0, 2, 2, 0);
        run_cmd(3'd4, 5'd5, 5'd9, 32'h1234_5678, 5'd12, 1'b0, 0, 0, 0);
        run_cmd(3'd1, 5'd2, 5'd17, 32'hA5A5_0001, 5'd20, 1'b0, 3, 0, 0);
        run_cmd(3'd0, 5'd0, 5'd4, 32'hBAD0_0001, 5'd6, 1'b1, 0, 0, 0);
        run_cmd(3'd2, 5'd31, 5'd4, 32'hBAD0_0002, 5'd6, 1'b0, 0, 0, 0);
        run_cmd(3'd6, 5'd8, 5'd4, 32'hBAD0_0003, 5'd6, 1'b0, 0, 0, 0);
        run_cmd(3'd1, 5'd10, 5'd11, 32'h0000_0101, 5'd1, 1'b0, 0, 0, 0);
        run_cmd(3'd2, 5'd11, 5'd12, 32'h0000_0202, 5'd1, 1'b0, 0, 0, 0);
        run_cmd(3'd3, 5'd12, NULLP, 32'h0000_0303, 5'd1, 1'b0, 0, 0, 0);
        run_cmd(3'd2, 5'd8, 5'd0, 32'hC0DE_0008, 5'd1, 1'b0, 1, 0, 5);

        // Reset in the middle of an insert's write phase.
        @(negedge clk);
        d_lat = 5; n_lat = 5; d_cnt = 0; n_cnt = 0; pop_cnt = 0;
        cmd_op = 3'd0; cmd_node_ptr = 5'd0; cmd_link_ptr = 5'd3; cmd_data = 32'h5EED_0004;
        free_ptr = 5'd4; free_empty = 1'b0; cmd_vld = 1'b1;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort_in_write", 64'(data_mem_wr_vld), 64'd1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid_outs");
        @(posedge clk);
        #1;
        check_outputs_zero("rst_held_outs");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("abort_pops", 64'(pop_cnt), 64'd0);
        check_eq("abort_writes", 64'(d_cnt + n_cnt), 64'd0);
        check_eq("abort_idle", 64'(cmd_rdy), 64'd1);
        check_eq("abort_no_rsp", 64'(rsp_vld), 64'd0);
        run_cmd(3'd0, 5'd0, 5'd3, 32'h5EED_0004, 5'd4, 1'b0, 0, 0, 0);

        for (int k = 0; k < 80; k++) begin
            r_op   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4))
                                                : 3'($urandom_range(5, 7));
            r_node = ($urandom_range(0, 7) == 0) ? NULLP : 5'($urandom_range(0, 30));
            r_fp   = 5'($urandom_range(0, 30));
            if (r_fp == r_node) r_fp = (r_fp == 5'd30) ? 5'd0 : r_fp + 5'd1;
            run_cmd(r_op, r_node, 5'($urandom_range(0, 31)), $urandom, r_fp,
                    $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 32; i++) begin
            check_eq($sformatf("img_data[%0d]", i), 64'(obs_data[i]), 64'(exp_data[i]));
            check_eq($sformatf("img_nxt[%0d]", i), 64'(obs_nxt[i]), 64'(exp_nxt[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ll_wr_ctrl_v3.md
Name: ll_wr_ctrl_v3

Overview:
Parametrised write controller for the linked-list engine. It sits between ll_mngr, the data/nxtptr memories and the free-pointer generator. It accepts one opcode-encoded command at a time over a valid/ready channel and sequences the required data-mem and nxtptr-mem writes. It allocates and pops free pointers for insert ops, does a second nxtptr write for mid-list inserts, and returns a pointer plus status on a valid/ready response channel.

Parameters:
DATA_W, 32, data memory word width
PTR_W, 5, node pointer / memory address width; list depth = 2**PTR_W
NULL_PTR, {PTR_W{1'b1}}, reserved end-of-list pointer; never a legal write address

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
cmd_vld  in  1  command valid
cmd_rdy  out  1  command ready
cmd_op  in  3  opcode
cmd_node_ptr  in  PTR_W  target node
cmd_link_ptr  in  PTR_W  next-pointer value to write
cmd_data  in  DATA_W  data to write
rsp_vld  out  1  response valid
rsp_rdy  in  1  response accepted
rsp_ptr  out  PTR_W  allocated node (alloc ops) or cmd_node_ptr
rsp_status  out  2  0 OK, 1 ERR_FULL, 2 ERR_PTR, 3 ERR_OP
data_mem_wr_vld / _addr / _data  out  1 / PTR_W / DATA_W  data memory write
data_mem_wr_done  in  1  data write complete
nxtptr_mem_wr_vld / _addr / _data  out  1 / PTR_W / PTR_W  nxtptr memory write
nxtptr_mem_wr_done  in  1  nxtptr write complete
free_ptr  in  PTR_W  next free node
free_empty  in  1  no free node
free_pop  out  1  consume free_ptr (1-cycle pulse)

Behaviour:
- Reset: synchronous, active-low, on clk. State goes to IDLE and all latched regs clear. While reset_n=0, every output is 0, including cmd_rdy. Reset mid-operation abandons the command with no response and no pop.
- Command fields are latched on the handshake (cmd_vld & cmd_rdy). Memory outputs are driven only from state and latched regs, with no combinational path from cmd_* to them.
- Opcodes:
  - 0 INS_ALLOC: new node at free_ptr; data=cmd_data, nxtptr=cmd_link_ptr.
  - 1 WR_NODE: data and nxtptr at node_ptr.
  - 2 WR_DATA: data only at node_ptr.
  - 3 WR_LINK: nxtptr only at node_ptr; data=link_ptr, which may be NULL_PTR.
  - 4 INS_AFTER: as INS_ALLOC, then nxtptr[node_ptr] = new pointer.
  - 5-7: ERR_OP.
- States: IDLE, WRITE, RELINK, POP, RESP.
- IDLE: cmd_rdy=1. On handshake:
  - illegal op -> RESP with ERR_OP.
  - node_ptr==NULL_PTR for ops 1-4 -> RESP with ERR_PTR.
  - alloc op (0/4) with free_empty=1 -> RESP with ERR_FULL.
  - alloc op otherwise: latch free_ptr as alloc_ptr.
  - no memory write occurs in any error case.
  - else -> WRITE.
- WRITE: assert vld for each memory the op needs. Each memory has a sticky done flag; its vld drops the cycle after its done is seen. The two dones may arrive in any order or together. Exit when all required dones are set: op 4 -> RELINK; ops 0 -> POP; ops 1-3 -> RESP.
- RELINK: nxtptr_mem_wr_vld=1, addr=node_ptr, data=alloc_ptr. On done -> POP.
- POP: free_pop=1 for exactly one cycle -> RESP. Pop happens only after all writes complete.
- RESP: rsp_vld=1 with rsp_ptr/rsp_status stable. Hold until rsp_rdy, then -> IDLE. cmd_rdy=0 in every non-IDLE state.
- Latency with zero-wait memories (done in the first vld cycle), counted from handshake to rsp_vld:
  - op 0: 3 cycles
  - op 4: 4 cycles
  - ops 1-3: 2 cycles
  - errors: 1 cycle
- free_ptr is sampled only at handshake; later changes are ignored.
- Back-to-back: a new command can be accepted in the cycle after the rsp handshake.

Decomposition:
- Package ll_pkg: t_ll_wr_op enum, t_ll_wr_status enum, t_ll_wr_v3_state enum, NULL_PTR helper function.
- Sub-module ll_mem_wr_port: vld/addr/data hold plus sticky done tracking, with a start/clear interface. Instantiated twice, once for data mem and once for nxtptr mem.

Test Plan:
- INS_ALLOC: cmd_data=0xDEADBEEF, link=7, free_ptr=3, dones after 2 cycles -> data[3]=0xDEADBEEF, nxtptr[3]=7, one free_pop, rsp OK ptr=3.
- INS_AFTER: node=5, link=9, free_ptr=12 -> nxtptr[12]=9, then nxtptr[5]=12, pop after relink done, rsp OK ptr=12.
- Skewed dones on WR_NODE, node=2: nxtptr done cycle 1, data done cycle 4 -> nxtptr vld drops after cycle 1, data vld held through cycle 4, single write each, rsp OK ptr=2.
- Errors:
  - INS_ALLOC with free_empty=1 -> ERR_FULL, no vld, no pop.
  - WR_DATA with node=31 (PTR_W=5) -> ERR_PTR.
  - op=6 -> ERR_OP.
- rsp_rdy held low 5 cycles -> rsp stable, cmd_rdy=0 throughout; next command accepted the cycle after the handshake.
- reset_n low during WRITE of INS_ALLOC -> outputs 0, IDLE, no pop. A repeat command after reset uses the same free_ptr.
